roi_frame_grabber: RTL and testbench

ROI_FRAME_GRABBER -- requirements
Module: roi_frame_grabber

---
 rtl/roi_grabber_pkg.sv | 22 ++
 rtl/roi_pixel_ram.sv | 24 ++
 rtl/roi_frame_grabber.sv | 180 ++++++++++++++++++
 tb/tb_roi_frame_grabber.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_grabber_pkg.sv
// Shared constants for the ROI frame grabber: FSM states,
// register map and CTRL bit positions.
package roi_grabber_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PTR    = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;
    localparam logic [2:0] REG_MODE   = 3'd3;
    localparam logic [2:0] REG_WCOUNT = 3'd4;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/roi_pixel_ram.sv
// Simple dual-port pixel store: one write port,
// one registered read port with 1-cycle latency.
module roi_pixel_ram #(
    parameter int DEPTH = 50176,
    parameter int AW    = 16,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/roi_frame_grabber.sv
// Captures a fixed screen window into pixel RAM and plays it back
// over Avalon-MM in raster or 8x8-block order.
module roi_frame_grabber
    import roi_grabber_pkg::*;
#(
    parameter int IMG_W   = 224,
    parameter int IMG_H   = 224,
    parameter int ORIG_X  = 208,
    parameter int ORIG_Y  = 128,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               avs_readdatavalid,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               frame_start,
    output logic               irq
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int NBX  = IMG_W / 8;
    localparam int NBY  = IMG_H / 8;
    localparam int BXW  = (NBX > 1) ? $clog2(NBX) : 1;
    localparam int BYW  = (NBY > 1) ? $clog2(NBY) : 1;

    localparam logic [AW-1:0]  LAST    = AW'(NPIX - 1);
    localparam logic [BXW-1:0] BX_LAST = BXW'(NBX - 1);
    localparam logic [BYW-1:0] BY_LAST = BYW'(NBY - 1);

    state_t         state;
    logic           irq_en;
    logic           block_mode;
    logic [15:0]    frame_count;
    logic [31:0]    wcount;
    logic [AW-1:0]  seq_pos;
    logic [2:0]     rx, ry;
    logic [BXW-1:0] bx;
    logic [BYW-1:0] by;
    logic           rd_ram;
    logic [31:0]    rd_reg;
    logic [PIX_W-1:0] ram_q;

    logic ctrl_wr, ptr_wr, mode_wr;
    logic abort, arm, go, finish;
    logic idle_like, data_rd;
    logic in_x, in_y, cap_we, last_px;
    logic [COORD_W-1:0] dx, dy;
    logic [AW-1:0] waddr, blk_addr, raddr;

    always_comb begin
        ctrl_wr   = avs_write && (avs_address == REG_CTRL);
        ptr_wr    = avs_write && (avs_address == REG_PTR);
        mode_wr   = avs_write && (avs_address == REG_MODE);
        idle_like = (state == ST_IDLE) || (state == ST_DONE);
        abort     = ctrl_wr && avs_writedata[CTRL_ABORT];
        arm       = ctrl_wr && avs_writedata[CTRL_ARM] && !abort && idle_like;
        go        = (state == ST_ARMED) && frame_start && !abort;
        data_rd   = avs_read && (avs_address == REG_DATA) && idle_like;

        in_x = (pix_x >= COORD_W'(ORIG_X)) &&
               (pix_x <= COORD_W'(ORIG_X + IMG_W - 1));
        in_y = (pix_y >= COORD_W'(ORIG_Y)) &&
               (pix_y <= COORD_W'(ORIG_Y + IMG_H - 1));
        cap_we  = (state == ST_CAPTURE) && pix_valid && in_x && in_y;
        dx      = pix_x - COORD_W'(ORIG_X);
        dy      = pix_y - COORD_W'(ORIG_Y);
        last_px = (dx == COORD_W'(IMG_W - 1)) &&
                  (dy == COORD_W'(IMG_H - 1));
        finish  = cap_we && last_px && !abort;
        waddr   = AW'(dy) * AW'(IMG_W) + AW'(dx);

        // {by,ry} is by*8+ry and {bx,rx} is bx*8+rx
        blk_addr = AW'({by, ry}) * AW'(IMG_W) + AW'({bx, rx});
        raddr    = block_mode ? blk_addr : seq_pos;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            frame_count <= '0;
            wcount      <= '0;
            irq_en      <= 1'b0;
            block_mode  <= 1'b0;
        end else begin
            unique case (1'b1)
                abort:   state <= ST_IDLE;
                arm:     state <= ST_ARMED;
                go:      state <= ST_CAPTURE;
                finish: begin
                    state       <= ST_DONE;
                    frame_count <= frame_count + 16'd1;
                end
                default: ;
            endcase
            if (go)
                wcount <= '0;
            else if (cap_we)
                wcount <= wcount + 32'd1;
            if (ctrl_wr)
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            if (mode_wr)
                block_mode <= avs_writedata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || mode_wr || (ptr_wr && block_mode)) begin
            seq_pos <= '0;
            rx      <= '0;
            ry      <= '0;
            bx      <= '0;
            by      <= '0;
        end else if (ptr_wr) begin
            seq_pos <= AW'(avs_writedata % 32'(NPIX));
            rx      <= '0;
            ry      <= '0;
            bx      <= '0;
            by      <= '0;
        end else if (data_rd) begin
            seq_pos <= (seq_pos == LAST) ? '0 : seq_pos + 1'b1;
            rx      <= rx + 3'd1;
            if (rx == 3'd7)
                ry <= ry + 3'd1;
            if (rx == 3'd7 && ry == 3'd7) begin
                bx <= (bx == BX_LAST) ? '0 : bx + 1'b1;
                if (bx == BX_LAST)
                    by <= (by == BY_LAST) ? '0 : by + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdatavalid <= 1'b0;
            rd_ram            <= 1'b0;
            rd_reg            <= '0;
        end else begin
            avs_readdatavalid <= avs_read;
            rd_ram            <= data_rd;
            rd_reg            <= '0;
            if (avs_read) begin
                unique case (avs_address)
                    REG_CTRL:   rd_reg <= {frame_count, 12'b0, irq_en,
                                           block_mode, state};
                    REG_PTR:    rd_reg <= 32'(seq_pos);
                    REG_MODE:   rd_reg <= {31'b0, block_mode};
                    REG_WCOUNT: rd_reg <= wcount;
                    default:    rd_reg <= '0;
                endcase
            end
        end
    end

    assign avs_readdata = rd_ram ? 32'(ram_q) : rd_reg;
    assign irq          = (state == ST_DONE) && irq_en;

    roi_pixel_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .PIX_W (PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (cap_we),
        .waddr (waddr),
        .wdata (pix_data),
        .raddr (raddr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_roi_frame_grabber.sv
// Self-checking bench for roi_frame_grabber: register table,
// frame streams and a read-data scoreboard.
`timescale 1ns/1ps
module tb_roi_frame_grabber;
    import roi_grabber_pkg::*;

    localparam int IW   = 32;
    localparam int IH   = 24;
    localparam int OX   = 208;
    localparam int OY   = 128;
    localparam int PW   = 8;
    localparam int CW   = 11;
    localparam int NPIX = IW * IH;
    localparam int NBX  = IW / 8;

    logic          clk;
    logic          reset_n;
    logic [2:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic          pix_valid;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [PW-1:0] pix_data;
    logic          frame_start;
    logic          irq;

    roi_frame_grabber #(
        .IMG_W(IW), .IMG_H(IH), .ORIG_X(OX), .ORIG_Y(OY),
        .PIX_W(PW), .COORD_W(CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .pix_valid         (pix_valid),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_data          (pix_data),
        .frame_start       (frame_start),
        .irq               (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];
    bit rd_was;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } op_t;
    op_t tbl[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wpix(input int wx, input int wy);
        return 32'((OX + wx + OY + wy) & 255);
    endfunction

    function automatic logic [31:0] blk_exp(input int i);
        int j, b, w;
        j = i % NPIX;
        b = j / 64;
        w = j % 64;
        return wpix((b % NBX) * 8 + w % 8, (b / NBX) * 8 + w / 8);
    endfunction

    // Scoreboard: every read issued pushes its expected data
    always @(posedge clk) begin
        rd_was = avs_read && reset_n;
        #1;
        if (rd_was || avs_readdatavalid)
            check("readdatavalid", 32'(avs_readdatavalid), 32'(rd_was));
        if (rd_was) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: unexpected read data %h",
                         avs_readdata);
            end else begin
                check("readdata", avs_readdata, expq.pop_front());
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        avs_read      = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        avs_write   = 1'b0;
        expq.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        avs_read    = 1'b0;
        avs_write   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic stream(input int max_wr, input logic [7:0] mask,
                          input bit extras);
        int n;
        bit inw;
        n = 0;
        for (int y = OY - 4; y <= OY + IH + 3 && n < max_wr; y++)
            for (int x = OX - 8; x <= OX + IW + 7 && n < max_wr; x++) begin
                inw = x >= OX && x < OX + IW && y >= OY && y < OY + IH;
                @(negedge clk);
                avs_read    = 1'b0;
                avs_write   = 1'b0;
                frame_start = 1'b0;
                pix_valid   = 1'b1;
                pix_x       = CW'(x);
                pix_y       = CW'(y);
                pix_data    = PW'((x + y) & 255) ^ mask;
                if (extras && inw && n == 100) begin
                    avs_address = REG_DATA;
                    avs_read    = 1'b1;
                    expq.push_back(32'd0);
                end
                if (extras && inw && n == 200) begin
                    avs_address   = REG_CTRL;
                    avs_writedata = 32'h5;
                    avs_write     = 1'b1;
                end
                if (extras && inw && n == 300)
                    frame_start = 1'b1;
                if (inw)
                    n++;
            end
        @(negedge clk);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        avs_read    = 1'b0;
        avs_write   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        pix_valid     = 1'b0;
        pix_x         = '0;
        pix_y         = '0;
        pix_data      = '0;
        frame_start   = 1'b0;

        tbl[0]  = '{1'b1, REG_PTR,    32'(IW)};
        tbl[1]  = '{1'b0, REG_DATA,   wpix(0, 1)};
        tbl[2]  = '{1'b0, REG_DATA,   wpix(1, 1)};
        tbl[3]  = '{1'b0, REG_PTR,    32'(IW + 2)};
        tbl[4]  = '{1'b1, REG_PTR,    32'(NPIX + 5)};
        tbl[5]  = '{1'b0, REG_PTR,    32'd5};
        tbl[6]  = '{1'b0, REG_DATA,   wpix(5, 0)};
        tbl[7]  = '{1'b1, REG_PTR,    32'(NPIX - 1)};
        tbl[8]  = '{1'b0, REG_DATA,   wpix(IW - 1, IH - 1)};
        tbl[9]  = '{1'b0, REG_PTR,    32'd0};
        tbl[10] = '{1'b0, REG_DATA,   wpix(0, 0)};
        tbl[11] = '{1'b0, 3'd5,       32'd0};
        tbl[12] = '{1'b0, 3'd7,       32'd0};
        tbl[13] = '{1'b0, REG_MODE,   32'd0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("irq after reset", 32'(irq), 32'd0);
        check("rdvalid after reset", 32'(avs_readdatavalid), 32'd0);
        check("readdata after reset", avs_readdata, 32'd0);
        rd(REG_CTRL, 32'd0);
        rd(REG_PTR, 32'd0);
        rd(REG_WCOUNT, 32'd0);

        pulse_fs();
        rd(REG_CTRL, 32'd0);
        wr(REG_CTRL, 32'h3);
        rd(REG_CTRL, 32'd0);
        wr(REG_CTRL, 32'h5);
        rd(REG_CTRL, 32'h9);
        rd(REG_DATA, 32'd0);
        rd(REG_PTR, 32'd0);
        rd(REG_WCOUNT, 32'd0);
        drain();
        check("irq armed", 32'(irq), 32'd0);

        pulse_fs();
        rd(REG_CTRL, 32'hA);
        rd(REG_WCOUNT, 32'd0);
        stream(1 << 30, 8'h00, 1'b1);
        rd(REG_CTRL, 32'h0001_000B);
        rd(REG_WCOUNT, 32'(NPIX));
        drain();
        check("irq done", 32'(irq), 32'd1);

        foreach (tbl[i]) begin
            if (tbl[i].wr)
                wr(tbl[i].addr, tbl[i].data);
            else
                rd(tbl[i].addr, tbl[i].data);
        end
        drain();

        wr(REG_CTRL, 32'h1);
        rd(REG_CTRL, 32'h0001_0001);
        drain();
        check("irq armed no en", 32'(irq), 32'd0);
        stream(1 << 30, 8'hFF, 1'b0);
        rd(REG_CTRL, 32'h0001_0001);
        rd(REG_WCOUNT, 32'(NPIX));
        rd(REG_DATA, 32'd0);
        wr(REG_CTRL, 32'h2);
        rd(REG_CTRL, 32'h0001_0000);

        wr(REG_MODE, 32'h1);
        rd(REG_CTRL, 32'h0001_0004);
        rd(REG_PTR, 32'd0);
        for (int i = 0; i <= NPIX; i++)
            rd(REG_DATA, blk_exp(i));
        rd(REG_PTR, 32'd1);
        wr(REG_PTR, 32'd77);
        rd(REG_PTR, 32'd0);
        rd(REG_DATA, wpix(0, 0));
        rd(REG_DATA, wpix(1, 0));
        wr(REG_MODE, 32'h0);
        rd(REG_PTR, 32'd0);
        rd(REG_CTRL, 32'h0001_0000);
        drain();

        wr(REG_CTRL, 32'h1);
        pulse_fs();
        stream(300, 8'h00, 1'b0);
        rd(REG_WCOUNT, 32'd300);
        rd(REG_CTRL, 32'h0001_0002);
        wr(REG_CTRL, 32'h2);
        rd(REG_CTRL, 32'h0001_0000);
        rd(REG_WCOUNT, 32'd300);
        drain();

        wr(REG_MODE, 32'h1);
        rd(REG_DATA, wpix(0, 0));
        rd(REG_DATA, wpix(1, 0));
        rd(REG_PTR, 32'd2);
        wr(REG_CTRL, 32'h5);
        pulse_fs();
        stream(50, 8'h00, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("readdata in reset", avs_readdata, 32'd0);
        check("rdvalid in reset", 32'(avs_readdatavalid), 32'd0);
        check("irq in reset", 32'(irq), 32'd0);
        rd(REG_CTRL, 32'd0);
        rd(REG_PTR, 32'd0);
        rd(REG_WCOUNT, 32'd0);
        rd(REG_MODE, 32'd0);
        rd(REG_DATA, wpix(0, 0));
        rd(REG_PTR, 32'd1);
        drain();

        check("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
